// File: rtl/eco32f_decode_queue.sv
// eco32f_decode_queue: fetch-to-decode instruction queue with load-use interlock bubbles.
// Define ECO32F_DECODE_QUEUE_BYPASS_EN to let a word skip the empty queue straight into the output slot.
module eco32f_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_insn,
  input  logic                     if_exc_ibus_fault,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic                     id_bubble,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_insn,
  output logic                     id_exc_ibus_fault,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] ECO32F_OP_LDW  = 6'h30;
  localparam logic [5:0] ECO32F_OP_LDH  = 6'h31;
  localparam logic [5:0] ECO32F_OP_LDHU = 6'h32;
  localparam logic [5:0] ECO32F_OP_LDB  = 6'h33;
  localparam logic [5:0] ECO32F_OP_LDBU = 6'h34;

  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_insn  [DEPTH];
  logic        q_fault [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          h_ld [LOAD_LAT];
  logic [4:0]    h_rd [LOAD_LAT];

  logic        full, empty, haz, pop, push, take, bubble, is_ld, new_ld;
  logic [4:0]  new_rd;
  logic [31:0] src_pc, src_insn;
  logic        src_fault;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign if_ready = !full;
  assign level    = count;
  assign pop      = !id_stall && !flush && !empty && !haz;

`ifdef ECO32F_DECODE_QUEUE_BYPASS_EN
  logic byp;
  assign src_pc    = empty ? if_pc : q_pc[rp];
  assign src_insn  = empty ? if_insn : q_insn[rp];
  assign src_fault = empty ? if_exc_ibus_fault : q_fault[rp];
  assign byp       = empty && if_valid && !id_stall && !flush;
  assign take      = pop || (byp && !haz);
  assign push      = if_valid && !full && !flush && !(byp && !haz);
  assign bubble    = !id_stall && !flush && haz && (!empty || byp);
`else
  assign src_pc    = q_pc[rp];
  assign src_insn  = q_insn[rp];
  assign src_fault = q_fault[rp];
  assign take      = pop;
  assign push      = if_valid && !full && !flush;
  assign bubble    = !id_stall && !flush && !empty && haz;
`endif

  // r0 loads never interlock; both source fields are checked regardless of format
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      haz = haz | (h_ld[i] && h_rd[i] != 5'd0 &&
                   (src_insn[25:21] == h_rd[i] || src_insn[20:16] == h_rd[i]));
  end

  assign is_ld  = src_insn[31:26] inside {ECO32F_OP_LDW, ECO32F_OP_LDH, ECO32F_OP_LDHU,
                                          ECO32F_OP_LDB, ECO32F_OP_LDBU};
  assign new_ld = take && is_ld;
  assign new_rd = new_ld ? src_insn[20:16] : 5'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wp]    <= if_pc;
      q_insn[wp]  <= if_insn;
      q_fault[wp] <= if_exc_ibus_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp                <= '0;
      rp                <= '0;
      count             <= '0;
      id_valid          <= 1'b0;
      id_bubble         <= 1'b0;
      id_pc             <= '0;
      id_insn           <= '0;
      id_exc_ibus_fault <= 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
        h_ld[i] <= 1'b0;
        h_rd[i] <= '0;
      end
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      id_valid  <= 1'b0;
      id_bubble <= 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
        h_ld[i] <= 1'b0;
        h_rd[i] <= '0;
      end
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (!id_stall) begin
        id_valid  <= take;
        id_bubble <= bubble;
        if (take) begin
          id_pc             <= src_pc;
          id_insn           <= src_insn;
          id_exc_ibus_fault <= src_fault;
        end
        for (int i = LOAD_LAT - 1; i > 0; i--) begin
          h_ld[i] <= h_ld[i-1];
          h_rd[i] <= h_rd[i-1];
        end
        h_ld[0] <= new_ld;
        h_rd[0] <= new_rd;
      end
    end
  end
endmodule

// File: tb/tb_eco32f_decode_queue.sv
// tb_eco32f_decode_queue: directed checks of queueing, interlock bubbles, stall, flush and reset.
module tb_eco32f_decode_queue;
  localparam logic [31:0] LDW_R5 = 32'hC025_0000;
  localparam logic [31:0] ADD_DEP = 32'h00A7_3000;
  localparam logic [31:0] ADD_IND = 32'h0022_4000;
  localparam logic [31:0] LDW_R0 = 32'hC020_0000;
  localparam logic [31:0] ADD_R0 = 32'h0007_3000;

  logic clk = 1'b0;
  logic rst, if_valid, if_fault, flush, id_stall;
  logic [31:0] if_pc, if_insn;
  logic if_ready, id_valid, id_bubble, id_fault;
  logic [31:0] id_pc, id_insn;
  logic [2:0] level;
  logic t3_ready, t3_valid, t3_bubble, t3_fault;
  logic [31:0] t3_pc, t3_insn;
  logic [2:0] t3_level;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eco32f_decode_queue dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
    .if_exc_ibus_fault(if_fault), .if_ready(if_ready), .flush(flush), .id_stall(id_stall),
    .id_valid(id_valid), .id_bubble(id_bubble), .id_pc(id_pc), .id_insn(id_insn),
    .id_exc_ibus_fault(id_fault), .level(level)
  );

  eco32f_decode_queue #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
    .if_exc_ibus_fault(if_fault), .if_ready(t3_ready), .flush(flush), .id_stall(id_stall),
    .id_valid(t3_valid), .id_bubble(t3_bubble), .id_pc(t3_pc), .id_insn(t3_insn),
    .id_exc_ibus_fault(t3_fault), .level(t3_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset id_valid: got %b want 0", id_valid); end
    n_checks++; if (id_bubble !== 1'b0) begin n_fail++; $display("FAIL reset id_bubble: got %b want 0", id_bubble); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset id_pc: got %h want 0", id_pc); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset level: got %0d want 0", level); end
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset if_ready: got %b want 1", if_ready); end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      if_valid = k < 8;
      if_pc = 32'h100 + 32'(4 * k);
      if_insn = if_pc;
      if_fault = k == 3;
      step();
      n_checks++;
      if (id_valid !== (k >= 1 && k <= 8)) begin n_fail++; $display("FAIL stream valid k=%0d: got %b want %b", k, id_valid, (k >= 1 && k <= 8)); end
      n_checks++;
      if (level !== (k < 8 ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL stream level k=%0d: got %0d want %0d", k, level, (k < 8 ? 1 : 0)); end
      if (k >= 1 && k <= 8) begin
        n_checks++;
        if (id_pc !== 32'h100 + 32'(4 * (k - 1)) || id_insn !== 32'h100 + 32'(4 * (k - 1)))
          begin n_fail++; $display("FAIL stream word k=%0d: got pc %h insn %h want %h", k, id_pc, id_insn, 32'h100 + 32'(4 * (k - 1))); end
        n_checks++;
        if (id_fault !== (k == 4)) begin n_fail++; $display("FAIL stream fault k=%0d: got %b want %b", k, id_fault, k == 4); end
      end
    end
    if_valid = 1'b0;
    if_fault = 1'b0;
  endtask

  task automatic test_load_use(input string name, input int n, input logic [31:0] w0, w1, w2,
                               input int e1, input int e3);
    logic [31:0] w [3];
    logic [31:0] last;
    logic f1, l1, f3, l3;
    int b1, g1, b3, g3;
    w[0] = w0; w[1] = w1; w[2] = w2;
    last = w[n-1];
    f1 = 0; l1 = 0; f3 = 0; l3 = 0; b1 = 0; g1 = 0; b3 = 0; g3 = 0;
    for (int c = 0; c < 14; c++) begin
      if_valid = c < n;
      if_insn = c < n ? w[c] : 32'h0;
      if_pc = 32'hA00 + 32'(4 * c);
      step();
      if (f1 && !l1) begin
        if (id_valid && id_insn == last) l1 = 1;
        else if (!id_valid) begin g1++; if (id_bubble) b1++; end
      end
      if (f3 && !l3) begin
        if (t3_valid && t3_insn == last) l3 = 1;
        else if (!t3_valid) begin g3++; if (t3_bubble) b3++; end
      end
      if (id_valid && id_insn == w[0]) f1 = 1;
      if (t3_valid && t3_insn == w[0]) f3 = 1;
    end
    if_valid = 1'b0;
    n_checks++; if (b1 !== e1) begin n_fail++; $display("FAIL %s lat1 bubbles: got %0d want %0d", name, b1, e1); end
    n_checks++; if (g1 !== e1) begin n_fail++; $display("FAIL %s lat1 gap: got %0d want %0d", name, g1, e1); end
    n_checks++; if (b3 !== e3) begin n_fail++; $display("FAIL %s lat3 bubbles: got %0d want %0d", name, b3, e3); end
    n_checks++; if (g3 !== e3) begin n_fail++; $display("FAIL %s lat3 gap: got %0d want %0d", name, g3, e3); end
  endtask

  task automatic test_fill_stall();
    logic rdy;
    int j, idx;
    logic [31:0] exp_pc [8];
    if_valid = 1'b1; if_pc = 32'h200; if_insn = 32'h200;
    step();
    if_valid = 1'b0;
    step();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_fail++; $display("FAIL fill pre-slot: got %b/%h want 1/200", id_valid, id_pc); end
    id_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if_valid = 1'b1; if_pc = 32'h300 + 32'(4 * k); if_insn = if_pc;
      n_checks++; if (if_ready !== (k < 4)) begin n_fail++; $display("FAIL fill if_ready k=%0d: got %b want %b", k, if_ready, k < 4); end
      step();
    end
    if_valid = 1'b0;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill level: got %0d want 4", level); end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_fail++; $display("FAIL fill slot held: got %b/%h want 1/200", id_valid, id_pc); end
    for (int k = 0; k < 4; k++) begin
      exp_pc[k] = 32'h300 + 32'(4 * k);
      exp_pc[k+4] = 32'h400 + 32'(4 * k);
    end
    id_stall = 1'b0;
    j = 0; idx = 0;
    for (int c = 0; c < 12; c++) begin
      if_valid = j < 4; if_pc = 32'h400 + 32'(4 * j); if_insn = if_pc;
      rdy = if_ready;
      step();
      if (rdy && j < 4) j++;
      if (id_valid) begin
        n_checks++;
        if (idx > 7 || id_pc !== exp_pc[idx & 7]) begin n_fail++; $display("FAIL drain order %0d: got %h want %h", idx, id_pc, exp_pc[idx & 7]); end
        idx++;
      end
    end
    if_valid = 1'b0;
    n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL drain count: got %0d want 8", idx); end
  endtask

  task automatic test_flush();
    if_valid = 1'b1; if_pc = 32'h500; if_insn = LDW_R5;
    step();
    if_valid = 1'b0;
    step();
    id_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if_valid = 1'b1; if_pc = 32'h500 + 32'(4 * k); if_insn = if_pc;
      step();
    end
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush pre-level: got %0d want 3", level); end
    flush = 1'b1; if_pc = 32'h600; if_insn = 32'h600;
    step();
    flush = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush level: got %0d want 0", level); end
    n_checks++; if (id_valid !== 1'b0 || id_bubble !== 1'b0) begin n_fail++; $display("FAIL flush slot: got v=%b b=%b want 0/0", id_valid, id_bubble); end
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush if_ready: got %b want 1", if_ready); end
    if_pc = 32'h700; if_insn = ADD_DEP;
    step();
    if_valid = 1'b0; id_stall = 1'b0;
    step();
    n_checks++; if (id_valid !== 1'b1 || id_bubble !== 1'b0 || id_pc !== 32'h700) begin n_fail++; $display("FAIL flush history lat1: got v=%b b=%b pc=%h want 1/0/700", id_valid, id_bubble, id_pc); end
    n_checks++; if (t3_valid !== 1'b1 || t3_bubble !== 1'b0 || t3_pc !== 32'h700) begin n_fail++; $display("FAIL flush history lat3: got v=%b b=%b pc=%h want 1/0/700", t3_valid, t3_bubble, t3_pc); end
    step();
  endtask

  task automatic test_reset_mid();
    if_valid = 1'b1; if_pc = 32'h800; if_insn = LDW_R5;
    step();
    if_valid = 1'b0;
    step();
    id_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if_valid = 1'b1; if_pc = 32'h800 + 32'(4 * k); if_insn = k == 1 ? ADD_DEP : if_pc;
      step();
    end
    if_valid = 1'b0;
    n_checks++; if (level !== 3'd4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL midrst pre: got level %0d ready %b want 4/0", level, if_ready); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (id_valid !== 1'b0 || id_bubble !== 1'b0) begin n_fail++; $display("FAIL midrst slot: got v=%b b=%b want 0/0", id_valid, id_bubble); end
    n_checks++; if (id_pc !== 32'h0 || id_insn !== 32'h0 || id_fault !== 1'b0) begin n_fail++; $display("FAIL midrst fields: got %h %h %b want 0", id_pc, id_insn, id_fault); end
    n_checks++; if (level !== 3'd0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL midrst level: got %0d ready %b want 0/1", level, if_ready); end
    n_checks++; if (t3_level !== 3'd0 || t3_valid !== 1'b0) begin n_fail++; $display("FAIL midrst lat3: got level %0d v=%b want 0/0", t3_level, t3_valid); end
    id_stall = 1'b0;
    if_valid = 1'b1; if_pc = 32'h900; if_insn = ADD_DEP;
    step();
    if_valid = 1'b0;
    step();
    n_checks++; if (id_valid !== 1'b1 || id_bubble !== 1'b0 || id_pc !== 32'h900) begin n_fail++; $display("FAIL midrst history lat1: got v=%b b=%b pc=%h want 1/0/900", id_valid, id_bubble, id_pc); end
    n_checks++; if (t3_valid !== 1'b1 || t3_bubble !== 1'b0) begin n_fail++; $display("FAIL midrst history lat3: got v=%b b=%b want 1/0", t3_valid, t3_bubble); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_insn = '0; if_fault = 1'b0;
    flush = 1'b0; id_stall = 1'b0;
    test_reset();
    test_stream();
    test_load_use("ldu_direct", 2, LDW_R5, ADD_DEP, 32'h0, 1, 3);
    test_load_use("ldu_gap1", 3, LDW_R5, ADD_IND, ADD_DEP, 0, 2);
    test_load_use("ldu_r0", 2, LDW_R0, ADD_R0, 32'h0, 0, 0);
    test_fill_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eco32f_decode_queue.md
# eco32f_decode_queue

Parametrised instruction queue and load-use interlock between the fetch and decode stages. Buffers up to DEPTH fetched words with a valid/ready handshake. Presents one registered instruction per cycle to decode. Inserts bubbles for load-use hazards over a configurable load latency, generalising the single-cycle bubble of the current decode stage.

## Interface

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- LOAD_LAT, 1: cycles a load result is unavailable to a following instruction; range 1..3.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- if_valid  input  1  fetch presents a word.
- if_pc  input  32  PC of the presented word.
- if_insn  input  32  instruction word.
- if_exc_ibus_fault  input  1  bus fault attached to the word.
- if_ready  output  1  queue can accept a word; equals !full, from registered count only.
- flush  input  1  discard all queued words, the output slot and the hazard history.
- id_stall  input  1  decode is stalled; the output slot holds.
- id_valid  output  1  the output slot holds a real instruction.
- id_bubble  output  1  the output slot is an interlock bubble.
- id_pc  output  32  registered PC.
- id_insn  output  32  registered instruction.
- id_exc_ibus_fault  output  1  registered fault flag.
- level  output  $clog2(DEPTH)+1  current queue occupancy.

## Operation

- **Push.** A push occurs when if_valid & if_ready & !flush. The word is written at the write pointer and the pointer is incremented modulo DEPTH.
- **Full queue.** When full, if_ready=0, and a simultaneous pop does not admit a push in the same cycle.
- **Output update.** When !id_stall, the output slot loads exactly one of the following, in priority order:
  - flush: id_valid=0, id_bubble=0.
  - Hazard on the head entry: id_valid=0, id_bubble=1. No pop.
  - Queue non-empty: pop the head; id_valid=1, id_bubble=0, and the fields are copied.
  - Otherwise, empty: id_valid=0, id_bubble=0. id_pc, id_insn and id_exc_ibus_fault keep their old values.
- **Hazard history.**
  - The history is a shift register of LOAD_LAT entries, each {ld, rd[4:0]}.
  - It shifts on every cycle with !id_stall.
  - The new entry is {1, insn[20:16]} when the popped word's opcode insn[31:26] is `ECO32F_OP_LDW, LDH, LDHU, LDB or LDBU. It is {0,0} for a bubble, an empty slot or a non-load.
- **Hazard condition.** The head's insn[25:21] or insn[20:16] equals the rd of any history entry with ld=1 and rd≠0.
  - Both source fields are always compared.
  - r0 never causes a hazard.
- **Stall.** When id_stall=1, the output slot and the history hold. Pushes still occur if there is space.
- **Flush.** flush=1 clears count, both pointers and all history entries on that edge. It overrides id_stall and ignores if_valid.
- **Occupancy.** level equals count. count changes by +1, −1 or 0 (push and pop together) and never goes outside 0..DEPTH.

## Timing

- **Reset.** rst=0 at an edge sets id_valid=0, id_bubble=0, id_pc=0, id_insn=0, id_exc_ibus_fault=0, level=0, pointers=0 and history cleared. if_ready=1 from the following cycle. Reset mid-operation discards all contents.
- **Latency without bypass.** A word pushed at edge E0 can appear in the output slot at E1 at the earliest, i.e. 2 cycles from if_valid to id_valid.
- **Throughput.** One push and one pop per cycle, sustained.
- **Bubbles per hazard.** A dependent instruction directly behind a load receives LOAD_LAT bubbles. With k independent instructions between them, it receives max(0, LOAD_LAT−k) bubbles.
- **Wrap-around.** Pointers wrap from DEPTH−1 to 0 with no lost or duplicated word.

## Configuration

- **ECO32F_DECODE_QUEUE_BYPASS_EN defined.** When count=0, !id_stall and !flush, a word presented with if_valid loads straight into the output slot on the same edge and is not written to the queue. This gives 1-cycle latency.
  - If the bypassed word itself hits a hazard, it is written to the queue instead and a bubble is issued.
- **Macro undefined.** Every word passes through the queue; latency is 2 cycles.

## Test plan

- **Reset then stream.** Reset, then stream 8 words PC 0x100..0x11C with id_stall=0.
  - Required: id_valid follows in order with no gaps after the first.
  - id_pc=0x100 appears 2 cycles after the first if_valid (1 cycle with bypass).
- **Load-use, LOAD_LAT=1.** Send ldw r5,0(r1) then add r6,r5,r7.
  - Required: exactly one id_bubble=1 cycle between them.
  - With LOAD_LAT=3: three bubbles. With one independent instruction in between: two bubbles.
- **Load to r0.** Send ldw r0 then add r6,r0,r7.
  - Required: no bubble.
- **Fill with stall, DEPTH=4.** Hold id_stall=1 and offer 6 words.
  - Required: if_ready drops after 4 accepts; level=4; the output slot is unchanged.
  - Release the stall: words appear in order, and the pointers wrap across 4 entries.
- **Flush mid-stream.** Assert flush with level=3, id_stall=1 and if_valid=1.
  - Required: next cycle level=0, id_valid=0, no stale word emitted.
  - A load in history before the flush does not bubble the next instruction.
- **Reset mid-operation.** Pulse rst=0 for one cycle while full, with a pending hazard.
  - Required: all outputs return to their reset values and if_ready=1.
